// File: rtl/down_counter_sequencer_pkg.sv
// Shared types and default sizes for the down-count sequencer slice.
package down_counter_seq_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_DIV_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/down_counter_sequencer_if.sv
// Configuration handshake, run control and status bundle of the sequencer.
interface down_counter_sequencer_if
  import down_counter_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DIV_W = DEFAULT_DIV_W
);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [WIDTH-1:0] cfg_count;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_reload;
  logic             pause;
  logic             abort;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;

  modport master (
    output cfg_valid, cfg_count, cfg_div, cfg_reload, pause, abort,
    input  cfg_ready, q, busy, done
  );

  modport slave (
    input  cfg_valid, cfg_count, cfg_div, cfg_reload, pause, abort,
    output cfg_ready, q, busy, done
  );

endinterface

// File: rtl/down_counter_sequencer_tick_prescaler.sv
// Prescale counter: raises tick on every (div+1)-th enabled clock.
module tick_prescaler
  import down_counter_seq_pkg::*;
#(
  parameter int DIV_W = DEFAULT_DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] pre_cnt_r;

  assign tick = en && (pre_cnt_r == div);

  // Prescale count register; wraps to zero on its own tick so it never passes div.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pre_cnt_r <= {DIV_W{1'b0}};
    end else if (clr) begin
      pre_cnt_r <= {DIV_W{1'b0}};
    end else if (en) begin
      if (tick) begin
        pre_cnt_r <= {DIV_W{1'b0}};
      end else begin
        pre_cnt_r <= pre_cnt_r + DIV_W'(1);
      end
    end else begin
      pre_cnt_r <= pre_cnt_r;
    end
  end

endmodule

// File: rtl/down_counter_sequencer.sv
// Programmable 4-bit down-count sequencer: handshake load, prescaled decrement,
// pause/abort control and a one-cycle terminal-count pulse with optional reload.
module down_counter_sequencer
  import down_counter_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DIV_W = DEFAULT_DIV_W
) (
  input logic                     clk,
  input logic                     rst,
  down_counter_sequencer_if.slave bus
);

  state_t           state_r, next_state_s;
  logic [WIDTH-1:0] q_r, q_next_s, load_val_r;
  logic [DIV_W-1:0] div_val_r;
  logic             reload_r, busy_r, done_r;
  logic             done_next_s, accept_s, clr_s, en_s, tick_s;

  // A HOLD cycle with pause already released counts like RUN, so an
  // N-cycle pause delays the countdown by exactly N clocks.
  assign en_s = ((state_r == RUN) || (state_r == HOLD)) && !bus.pause && !bus.abort;

  tick_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en_s),
    .clr  (clr_s),
    .div  (div_val_r),
    .tick (tick_s)
  );

  assign bus.cfg_ready = (state_r == IDLE);
  assign bus.q         = q_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;

  // Next-state and count decode; priority abort > pause > tick.
  always_comb begin
    next_state_s = state_r;
    q_next_s     = q_r;
    done_next_s  = 1'b0;
    accept_s     = 1'b0;
    clr_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.cfg_valid) begin
          accept_s     = 1'b1;
          clr_s        = 1'b1;
          q_next_s     = bus.cfg_count;
          next_state_s = RUN;
        end else begin
          next_state_s = IDLE;
        end
      end
      RUN, HOLD: begin
        if (bus.abort) begin
          clr_s        = 1'b1;
          q_next_s     = {WIDTH{1'b0}};
          next_state_s = IDLE;
        end else if (bus.pause) begin
          next_state_s = HOLD;
        end else begin
          next_state_s = RUN;
          if (tick_s) begin
            if (q_r != {WIDTH{1'b0}}) begin
              q_next_s = q_r - WIDTH'(1);
            end else begin
              done_next_s = 1'b1;
              clr_s       = 1'b1;
              if (reload_r) begin
                q_next_s = load_val_r;
              end else begin
                next_state_s = IDLE;
              end
            end
          end else begin
            q_next_s = q_r;
          end
        end
      end
      default: begin
        clr_s        = 1'b1;
        q_next_s     = {WIDTH{1'b0}};
        next_state_s = IDLE;
      end
    endcase
  end

  // State, outputs and captured configuration registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= IDLE;
      q_r        <= {WIDTH{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      load_val_r <= {WIDTH{1'b0}};
      div_val_r  <= {DIV_W{1'b0}};
      reload_r   <= 1'b0;
    end else begin
      state_r <= next_state_s;
      q_r     <= q_next_s;
      busy_r  <= (next_state_s != IDLE);
      done_r  <= done_next_s;
      if (accept_s) begin
        load_val_r <= bus.cfg_count;
        div_val_r  <= bus.cfg_div;
        reload_r   <= bus.cfg_reload;
      end else begin
        load_val_r <= load_val_r;
        div_val_r  <= div_val_r;
        reload_r   <= reload_r;
      end
    end
  end

endmodule

// File: tb/tb_down_counter_sequencer.sv
// Bench for down_counter_sequencer: directed scenarios plus random traffic,
// all checked against an elapsed-time model of the countdown.
module tb_down_counter_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  // Reference model state: a run is described by its configuration and the
  // number of un-paused clocks elapsed since acceptance.
  bit m_act = 1'b0;
  bit m_r = 1'b0;
  bit m_done = 1'b0;
  int m_q = 0;
  int m_c = 0;
  int m_d = 0;
  int m_e = 0;

  down_counter_sequencer_if #(.WIDTH(4), .DIV_W(4)) bus ();

  down_counter_sequencer #(.WIDTH(4), .DIV_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    if (!rst) begin
      m_act = 1'b0; m_q = 0; m_done = 1'b0; m_e = 0;
    end else begin
      m_done = 1'b0;
      if (!m_act) begin
        if (bus.cfg_valid === 1'b1) begin
          m_act = 1'b1;
          m_c = int'(bus.cfg_count);
          m_d = int'(bus.cfg_div);
          m_r = bus.cfg_reload;
          m_e = 0;
          m_q = m_c;
        end
      end else if (bus.abort === 1'b1) begin
        m_act = 1'b0;
        m_q = 0;
      end else if (bus.pause !== 1'b1) begin
        m_e++;
        if (m_e == (m_c + 1) * (m_d + 1)) begin
          m_done = 1'b1;
          m_e = 0;
          if (m_r) begin
            m_q = m_c;
          end else begin
            m_act = 1'b0;
            m_q = 0;
          end
        end else begin
          m_q = m_c - m_e / (m_d + 1);
        end
      end
    end
  endtask

  function automatic logic [6:0] obs();
    return {bus.q, bus.busy, bus.done, bus.cfg_ready};
  endfunction

  function automatic logic [6:0] expv();
    logic [3:0] qe;
    qe = 4'(m_q);
    return {qe, m_act, m_done, !m_act};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic start(input int c, input int d, input bit r);
    bus.cfg_valid  = 1'b1;
    bus.cfg_count  = 4'(c);
    bus.cfg_div    = 4'(d);
    bus.cfg_reload = r;
    tick();
    bus.cfg_valid  = 1'b0;
    bus.cfg_count  = 4'($urandom);
    bus.cfg_div    = 4'($urandom);
    bus.cfg_reload = 1'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.cfg_valid = 1'b1;
    bus.cfg_count = 4'd9;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL reset_cycle i=%0d got=%h want=%h", i, obs(), expv());
      end
    end
    checks++;
    if ({bus.q, bus.busy, bus.done, bus.cfg_ready} !== 7'b0000_001) begin
      failures++;
      $display("FAIL reset_values got q=%0d busy=%b done=%b rdy=%b want q=0 busy=0 done=0 rdy=1",
               bus.q, bus.busy, bus.done, bus.cfg_ready);
    end
    bus.cfg_valid = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_basic();
    int ndone = 0;
    int done_at = -1;
    logic busy_at_done = 1'b1;
    start(3, 1, 1'b0);
    checks++;
    if (obs() !== expv()) begin
      failures++;
      $display("FAIL basic_accept got=%h want=%h", obs(), expv());
    end
    for (int k = 1; k <= 12; k++) begin
      tick();
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL basic_cycle k=%0d got=%h want=%h", k, obs(), expv());
      end
      if (bus.done === 1'b1) begin
        ndone++; done_at = k; busy_at_done = bus.busy;
      end
    end
    checks++;
    if (done_at !== 8 || ndone !== 1 || busy_at_done !== 1'b0) begin
      failures++;
      $display("FAIL basic_done got at=%0d n=%0d busy=%b want at=8 n=1 busy=0",
               done_at, ndone, busy_at_done);
    end
  endtask

  task automatic test_reload();
    int ndone = 0;
    start(2, 0, 1'b1);
    for (int k = 1; k <= 9; k++) begin
      tick();
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL reload_cycle k=%0d got=%h want=%h", k, obs(), expv());
      end
      if (bus.done === 1'b1) ndone++;
    end
    checks++;
    if (ndone !== 3 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL reload_count got n=%0d busy=%b want n=3 busy=1", ndone, bus.busy);
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    checks++;
    if (obs() !== expv()) begin
      failures++;
      $display("FAIL reload_abort got=%h want=%h", obs(), expv());
    end
  endtask

  task automatic test_pause();
    int done_at = -1;
    start(5, 2, 1'b0);
    for (int k = 1; k <= 26; k++) begin
      bus.pause = (k >= 6 && k <= 9);
      tick();
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL pause_cycle k=%0d got=%h want=%h", k, obs(), expv());
      end
      if (bus.done === 1'b1) done_at = k;
    end
    bus.pause = 1'b0;
    checks++;
    if (done_at !== 22) begin
      failures++;
      $display("FAIL pause_delay got done at=%0d want 22", done_at);
    end
  endtask

  task automatic test_abort_hold();
    start(7, 1, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      bus.pause = (k >= 3);
      bus.abort = (k == 6);
      if (k >= 6) begin
        bus.cfg_valid = 1'b1; bus.cfg_count = 4'd2; bus.cfg_div = 4'd0; bus.cfg_reload = 1'b0;
      end
      tick();
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL abort_cycle k=%0d got=%h want=%h", k, obs(), expv());
      end
      if (k == 6) begin
        checks++;
        if (bus.q !== 4'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
          failures++;
          $display("FAIL abort_hold got q=%0d busy=%b done=%b want q=0 busy=0 done=0",
                   bus.q, bus.busy, bus.done);
        end
      end
      if (k == 7) begin
        checks++;
        if (bus.q !== 4'd2 || bus.busy !== 1'b1) begin
          failures++;
          $display("FAIL abort_reaccept got q=%0d busy=%b want q=2 busy=1", bus.q, bus.busy);
        end
      end
    end
    bus.cfg_valid = 1'b0;
    bus.pause = 1'b0;
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
  endtask

  task automatic test_zero();
    int done_at = -1;
    start(0, 3, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      tick();
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL zero_cycle k=%0d got=%h want=%h", k, obs(), expv());
      end
      if (bus.done === 1'b1) done_at = k;
    end
    checks++;
    if (done_at !== 4) begin
      failures++;
      $display("FAIL zero_done got at=%0d want 4", done_at);
    end
  endtask

  task automatic test_reset_mid();
    start(6, 1, 1'b1);
    for (int k = 1; k <= 5; k++) tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({bus.q, bus.busy, bus.done, bus.cfg_ready} !== 7'b0000_001) begin
      failures++;
      $display("FAIL reset_mid got q=%0d busy=%b done=%b rdy=%b want q=0 busy=0 done=0 rdy=1",
               bus.q, bus.busy, bus.done, bus.cfg_ready);
    end
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL reset_mid_after k=%0d got=%h want=%h", k, obs(), expv());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      rst            = ($urandom_range(0, 299) != 0);
      bus.cfg_valid  = ($urandom_range(0, 3) == 0);
      bus.cfg_count  = 4'($urandom);
      bus.cfg_div    = 4'($urandom_range(0, 3));
      bus.cfg_reload = 1'($urandom);
      bus.pause      = ($urandom_range(0, 5) == 0);
      bus.abort      = ($urandom_range(0, 39) == 0);
      tick();
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL random_cycle i=%0d got=%h want=%h", i, obs(), expv());
      end
    end
    rst = 1'b1;
    bus.cfg_valid = 1'b0;
    bus.pause = 1'b0;
    bus.abort = 1'b0;
  endtask

  initial begin
    bus.cfg_valid  = 1'b0;
    bus.cfg_count  = 4'd0;
    bus.cfg_div    = 4'd0;
    bus.cfg_reload = 1'b0;
    bus.pause      = 1'b0;
    bus.abort      = 1'b0;
    test_reset();
    test_basic();
    test_reload();
    test_pause();
    test_abort_hold();
    test_zero();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
